// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one external ALU between two requesters.
// An accepted operation is held on alu_op for LATENCY cycles and its result is returned over valid/ready.
module alu_share_arbiter #(
    parameter int OP_W    = 113,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_a,
    output logic            req_ready_a,
    input  logic [OP_W-1:0] req_op_a,
    input  logic            req_valid_b,
    output logic            req_ready_b,
    input  logic [OP_W-1:0] req_op_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [31:0]     alu_result,
    input  logic            alu_zero,
    output logic            resp_valid,
    output logic            resp_id,
    output logic [31:0]     resp_result,
    output logic            resp_zero,
    input  logic            resp_ready,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q;
    logic            last_grant_q;
    logic [3:0]      cnt_q;
    logic [OP_W-1:0] alu_op_q;
    logic            resp_valid_q;
    logic            resp_id_q;
    logic [31:0]     resp_result_q;
    logic            resp_zero_q;

    logic win_b_d;
    logic accept_d;

    // On a tie B wins only when A held the last grant.
    assign win_b_d  = req_valid_b & (~req_valid_a | ~last_grant_q);
    assign req_ready_a = ~rst & (state_q == IDLE) & req_valid_a & ~win_b_d;
    assign req_ready_b = ~rst & (state_q == IDLE) & win_b_d;
    assign accept_d = req_ready_a | req_ready_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            cnt_q         <= 4'd0;
            alu_op_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= 32'd0;
            resp_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        alu_op_q     <= win_b_d ? req_op_b : req_op_a;
                        resp_id_q    <= win_b_d;
                        last_grant_q <= win_b_d;
                        cnt_q        <= 4'(LATENCY);
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        resp_result_q <= alu_result;
                        resp_zero_q   <= alu_zero;
                        resp_valid_q  <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_op      = alu_op_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: LATENCY=1 instance driven from a vector table,
// LATENCY=3 instance used for the reset-during-execute sequence.
module tb_alu_share_arbiter;

    localparam int OP_W = 113;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // LATENCY=1 instance signals
    logic            rst1, va1, vb1, rr1;
    logic [OP_W-1:0] opa1, opb1;
    logic            rdya1, rdyb1, rv1, rid1, rz1, busy1;
    logic [31:0]     rres1, ares1;
    logic            azero1;
    logic [OP_W-1:0] aop1;

    // LATENCY=3 instance signals
    logic            rst3, va3, vb3, rr3;
    logic [OP_W-1:0] opa3, opb3;
    logic            rdya3, rdyb3, rv3, rid3, rz3, busy3;
    logic [31:0]     rres3, ares3;
    logic            azero3;
    logic [OP_W-1:0] aop3;

    alu_share_arbiter #(.OP_W(OP_W), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1),
        .req_valid_a(va1), .req_ready_a(rdya1), .req_op_a(opa1),
        .req_valid_b(vb1), .req_ready_b(rdyb1), .req_op_b(opb1),
        .alu_op(aop1), .alu_result(ares1), .alu_zero(azero1),
        .resp_valid(rv1), .resp_id(rid1), .resp_result(rres1), .resp_zero(rz1),
        .resp_ready(rr1), .busy(busy1)
    );

    alu_share_arbiter #(.OP_W(OP_W), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3),
        .req_valid_a(va3), .req_ready_a(rdya3), .req_op_a(opa3),
        .req_valid_b(vb3), .req_ready_b(rdyb3), .req_op_b(opb3),
        .alu_op(aop3), .alu_result(ares3), .alu_zero(azero3),
        .resp_valid(rv3), .resp_id(rid3), .resp_result(rres3), .resp_zero(rz3),
        .resp_ready(rr3), .busy(busy3)
    );

    // Packs {ReadData1, ReadData2, imm32=0, ALUSrc=0, ALUOp, funct3, funct7=0, Ftype=0}.
    function automatic logic [OP_W-1:0] mkop(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] aluop, input logic [2:0] f3);
        return {a, b, 32'd0, 1'b0, aluop, f3, 7'd0, 4'd0};
    endfunction

    // Stand-in for the external ALU: 00 add, 01 subtract, zero when result is 0.
    function automatic logic [32:0] alu_f(input logic [OP_W-1:0] op);
        logic [31:0] a, b, r;
        a = op[112:81];
        b = op[16] ? op[48:17] : op[80:49];
        r = (op[15:14] == 2'b01) ? a - b : a + b;
        return {(r == 32'd0), r};
    endfunction

    always_comb {azero1, ares1} = alu_f(aop1);
    always_comb {azero3, ares3} = alu_f(aop3);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic            va;
        logic            vb;
        logic [OP_W-1:0] opa;
        logic [OP_W-1:0] opb;
        logic            rr;
        logic            ea;
        logic            eb;
        logic            ev;
        logic            eid;
        logic [31:0]     eres;
        logic            ez;
        logic            ebusy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic va, vb, input logic [OP_W-1:0] opa, opb,
                                 input logic rr, ea, eb, ev, eid,
                                 input logic [31:0] eres, input logic ez, ebusy);
        vec_t v;
        v.va = va; v.vb = vb; v.opa = opa; v.opb = opb; v.rr = rr;
        v.ea = ea; v.eb = eb; v.ev = ev; v.eid = eid; v.eres = eres; v.ez = ez; v.ebusy = ebusy;
        return v;
    endfunction

    // Drives one cycle of inputs after the falling edge and checks the outputs seen in that cycle.
    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        va1 = v.va; vb1 = v.vb; opa1 = v.opa; opb1 = v.opb; rr1 = v.rr;
        #1;
        chk({tag, ".rdy_a"}, 128'(rdya1), 128'(v.ea));
        chk({tag, ".rdy_b"}, 128'(rdyb1), 128'(v.eb));
        chk({tag, ".valid"}, 128'(rv1), 128'(v.ev));
        chk({tag, ".id"},    128'(rid1), 128'(v.eid));
        chk({tag, ".result"}, 128'(rres1), 128'(v.eres));
        chk({tag, ".zero"},  128'(rz1), 128'(v.ez));
        chk({tag, ".busy"},  128'(busy1), 128'(v.ebusy));
    endtask

    task automatic reset1(input string tag);
        @(negedge clk);
        rst1 = 1'b1; va1 = 1'b1; vb1 = 1'b1; rr1 = 1'b0;
        #1;
        chk({tag, ".rdy_a"}, 128'(rdya1), 128'd0);
        chk({tag, ".rdy_b"}, 128'(rdyb1), 128'd0);
        chk({tag, ".valid"}, 128'(rv1), 128'd0);
        chk({tag, ".busy"},  128'(busy1), 128'd0);
        chk({tag, ".alu_op"}, 128'(aop1), 128'd0);
        chk({tag, ".result"}, 128'(rres1), 128'd0);
        chk({tag, ".id"},    128'(rid1), 128'd0);
        @(negedge clk);
        rst1 = 1'b0; va1 = 1'b0; vb1 = 1'b0;
    endtask

    task automatic step3(input string tag, input logic va, input logic rr,
                         input logic ev, input logic [31:0] eres, input logic ebusy);
        @(negedge clk);
        va3 = va; rr3 = rr;
        #1;
        chk({tag, ".valid"}, 128'(rv3), 128'(ev));
        chk({tag, ".busy"},  128'(busy3), 128'(ebusy));
        if (ev) chk({tag, ".result"}, 128'(rres3), 128'(eres));
    endtask

    initial begin
        logic [OP_W-1:0] op_add, op_beq, op_a34, op_b10, op_b20, op_a12, z;
        op_add = mkop(32'd5, 32'd7, 2'b00, 3'b000);
        op_beq = mkop(32'd9, 32'd9, 2'b01, 3'b000);
        op_a34 = mkop(32'd3, 32'd4, 2'b00, 3'b000);
        op_b10 = mkop(32'd10, 32'd2, 2'b01, 3'b000);
        op_b20 = mkop(32'd20, 32'd5, 2'b01, 3'b000);
        op_a12 = mkop(32'd1, 32'd2, 2'b00, 3'b000);
        z = '0;

        rst1 = 1'b1; va1 = 1'b0; vb1 = 1'b0; rr1 = 1'b0; opa1 = '0; opb1 = '0;
        rst3 = 1'b1; va3 = 1'b0; vb3 = 1'b0; rr3 = 1'b0; opa3 = '0; opb3 = '0;

        reset1("rst0");

        // Single A add, then BEQ producing the zero flag
        tbl.push_back(mkv(1, 0, op_add, z, 1,  1, 0, 0, 0, 32'd0,  0, 0));
        tbl.push_back(mkv(0, 0, op_add, z, 1,  0, 0, 0, 0, 32'd0,  0, 1));
        tbl.push_back(mkv(0, 0, op_add, z, 1,  0, 0, 1, 0, 32'd12, 0, 1));
        tbl.push_back(mkv(0, 0, op_add, z, 1,  0, 0, 0, 0, 32'd12, 0, 0));
        tbl.push_back(mkv(1, 0, op_beq, z, 1,  1, 0, 0, 0, 32'd12, 0, 0));
        tbl.push_back(mkv(0, 0, op_beq, z, 1,  0, 0, 0, 0, 32'd12, 0, 1));
        tbl.push_back(mkv(0, 0, op_beq, z, 1,  0, 0, 1, 0, 32'd0,  1, 1));
        tbl.push_back(mkv(0, 0, op_beq, z, 1,  0, 0, 0, 0, 32'd0,  1, 0));
        for (int i = 0; i < tbl.size(); i++) apply($sformatf("t1_%0d", i), tbl[i]);

        // Contention from reset: A, B, A, B, then B alone every third cycle
        reset1("rst1");
        tbl.delete();
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(mkv(1, 1, op_a34, op_b10, 1,  1, 0, 0, 1'(k), k ? 32'd8 : 32'd0, 0, 0));
            tbl.push_back(mkv(1, 1, op_a34, op_b10, 1,  0, 0, 0, 0, k ? 32'd8 : 32'd0, 0, 1));
            tbl.push_back(mkv(1, 1, op_a34, op_b10, 1,  0, 0, 1, 0, 32'd7, 0, 1));
            tbl.push_back(mkv(1, 1, op_a34, op_b10, 1,  0, 1, 0, 0, 32'd7, 0, 0));
            tbl.push_back(mkv(1, 1, op_a34, op_b10, 1,  0, 0, 0, 1, 32'd7, 0, 1));
            tbl.push_back(mkv(1, 1, op_a34, op_b10, 1,  0, 0, 1, 1, 32'd8, 0, 1));
        end
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mkv(0, 1, z, op_b10, 1,  0, 1, 0, 1, 32'd8, 0, 0));
            tbl.push_back(mkv(0, 1, z, op_b10, 1,  0, 0, 0, 1, 32'd8, 0, 1));
            tbl.push_back(mkv(0, 1, z, op_b10, 1,  0, 0, 1, 1, 32'd8, 0, 1));
        end
        tbl.push_back(mkv(0, 0, z, z, 1,  0, 0, 0, 1, 32'd8, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply($sformatf("t2_%0d", i), tbl[i]);

        // Backpressure: B result held four cycles while A waits
        apply("bp_acc", mkv(0, 1, z, op_b20, 0,  0, 1, 0, 1, 32'd8, 0, 0));
        apply("bp_exe", mkv(1, 0, op_a12, z, 0,  0, 0, 0, 1, 32'd8, 0, 1));
        for (int i = 0; i < 4; i++)
            apply($sformatf("bp_hold%0d", i), mkv(1, 0, op_a12, z, 0,  0, 0, 1, 1, 32'd15, 0, 1));
        apply("bp_hs",  mkv(1, 0, op_a12, z, 1,  0, 0, 1, 1, 32'd15, 0, 1));
        apply("bp_accA", mkv(1, 0, op_a12, z, 1,  1, 0, 0, 1, 32'd15, 0, 0));
        apply("bp_exeA", mkv(0, 0, op_a12, z, 1,  0, 0, 0, 0, 32'd15, 0, 1));
        apply("bp_rspA", mkv(0, 0, op_a12, z, 1,  0, 0, 1, 0, 32'd3, 0, 1));
        apply("bp_end",  mkv(0, 0, op_a12, z, 1,  0, 0, 0, 0, 32'd3, 0, 0));

        // Reset while executing on the LATENCY=3 instance
        @(negedge clk);
        rst3 = 1'b0; opa3 = op_add;
        step3("r3_acc", 1, 1, 0, 32'd0, 0);
        chk("r3_acc.rdy_a", 128'(rdya3), 128'd1);
        step3("r3_exe", 0, 1, 0, 32'd0, 1);
        chk("r3_exe.alu_op", 128'(aop3), 128'(op_add));
        @(negedge clk);
        rst3 = 1'b1; va3 = 1'b1;
        #1;
        chk("r3_rst.busy",  128'(busy3), 128'd0);
        chk("r3_rst.valid", 128'(rv3), 128'd0);
        chk("r3_rst.alu_op", 128'(aop3), 128'd0);
        chk("r3_rst.rdy_a", 128'(rdya3), 128'd0);
        @(negedge clk);
        rst3 = 1'b0; va3 = 1'b0;
        for (int i = 0; i < 5; i++) step3($sformatf("r3_quiet%0d", i), 0, 1, 0, 32'd0, 0);
        step3("r3_acc2", 1, 1, 0, 32'd0, 0);
        chk("r3_acc2.rdy_a", 128'(rdya3), 128'd1);
        step3("r3_e1", 0, 1, 0, 32'd0, 1);
        step3("r3_e2", 0, 1, 0, 32'd0, 1);
        step3("r3_e3", 0, 1, 0, 32'd0, 1);
        step3("r3_rsp", 0, 1, 1, 32'd12, 1);
        chk("r3_rsp.id", 128'(rid3), 128'd0);
        step3("r3_done", 0, 1, 0, 32'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Time-shares one ALU instance between two requesters: requester A (main execute path) and requester B (auxiliary/debug or coprocessor path).
- Each request carries a packed ALU operation. The block grants one request at a time, round-robin, and drives the captured operation onto the ALU inputs.
- It waits a fixed number of cycles for the result, registers it, and returns it to the granted requester over a valid/ready handshake.
- It sits between the requesters and the ALU; the ALU instance is external and connected through the alu_* ports.

Parameters:
- OP_W, 113, packed operation width. Layout MSB→LSB: ReadData1[32], ReadData2[32], imm32[32], ALUSrc[1], ALUOp[2], funct3[3], funct7[7], Ftype[4].
- LATENCY, 1, cycles from operands stable at ALU inputs to result sampled. Legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid_a  input  1  requester A has an operation.
- req_ready_a  output  1  A's operation accepted this cycle.
- req_op_a  input  OP_W  A's packed operation.
- req_valid_b  input  1  requester B has an operation.
- req_ready_b  output  1  B's operation accepted this cycle.
- req_op_b  input  OP_W  B's packed operation.
- alu_op  output  OP_W  registered operation driven to the ALU.
- alu_result  input  32  ALUResult from the ALU.
- alu_zero  input  1  zero/branch flag from the ALU.
- resp_valid  output  1  result available.
- resp_id  output  1  owner of the result: 0=A, 1=B.
- resp_result  output  32  registered ALU result.
- resp_zero  output  1  registered zero flag.
- resp_ready  input  1  owner consumes the result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=1 (B), so A wins the first tie.
  - alu_op=0, resp_result=0, resp_zero=0, resp_id=0, resp_valid=0, busy=0, counter=0.
  - req_ready_a and req_ready_b are forced 0 while rst is high.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection is combinational. Only A valid → A. Only B valid → B. Both valid → the requester ≠ last_grant.
  - req_ready_x=1 for the winner only. Both readys stay 0 outside IDLE.
  - On the edge where the winner's valid & ready: alu_op←winner's op, resp_id←winner, last_grant←winner, counter←LATENCY, go EXEC.
  - No valid request → stay in IDLE.
- EXEC:
  - alu_op holds constant.
  - Each edge, counter decrements.
  - On the edge where counter==1: resp_result←alu_result, resp_zero←alu_zero, resp_valid←1, go RESP.
  - Net effect: resp_valid rises LATENCY edges after the accept edge.
- RESP:
  - resp_valid, resp_result, resp_zero and resp_id hold stable until resp_ready=1.
  - On the edge where resp_valid & resp_ready: resp_valid←0, go IDLE.
  - There is no accept in that same cycle. Minimum issue interval is LATENCY+2 cycles.
- Request side:
  - req_op_x is sampled only on its accept edge.
  - A requester may drop valid before it is granted, with no side effects.
- Fairness: both requesters continuously valid → grants alternate A, B, A, B. A lone requester is granted every issue slot.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no response is ever produced, and the block returns to IDLE with reset values.
- resp_ready while not in RESP: ignored.
- alu_op in IDLE after the first op: holds the last value (not cleared).
- No arithmetic in this block; all data is passed through without width change.

Test Plan:
1. Single A add, LATENCY=1:
   - Stimulus: req_op_a = {ReadData1=5, ReadData2=7, ALUSrc=0, ALUOp=00}, resp_ready=1.
   - Required: req_ready_a=1 in the accept cycle; resp_valid=1, resp_id=0, resp_result=12 exactly 1 edge later; resp_valid=0 one edge after that.
2. Simultaneous contention:
   - Stimulus: A and B valid continuously from reset; A op 3+4, B op 10−2 (ALUOp=01, funct3=000); resp_ready=1.
   - Required: responses in order id 0 (result 7), id 1 (result 8), id 0, id 1; never two consecutive grants to one side.
3. Backpressure:
   - Stimulus: a B request; resp_ready held 0 for 4 cycles after resp_valid rises.
   - Required: resp_result and resp_id held stable; busy=1; req_ready_a=0 despite req_valid_a=1; A is accepted only in the cycle after the handshake.
4. Branch flag:
   - Stimulus: A op with ReadData1=9, ReadData2=9, ALUOp=01, funct3=000 (BEQ).
   - Required: resp_zero=1, resp_result=0.
5. Reset mid-EXEC, LATENCY=3:
   - Stimulus: assert rst one cycle after accept.
   - Required: outputs immediately at reset values; no resp_valid appears after rst deasserts; the next A request behaves as in test 1 with 3-edge latency.
6. Lone requester:
   - Stimulus: B valid continuously, A idle, resp_ready=1, LATENCY=1.
   - Required: B is accepted every 3 cycles; every response has resp_id=1.
